dmem_arbiter: RTL
=================

# dmem_arbiter

Sequencer and arbiter for the single-port data memory behind the Mbox. Two requesters share the memory: the pipeline memory stage (port P) and a DMA/debug engine (port D). The block accepts one access at a time, drives the memory for a fixed number of cycles, and returns read data with a one-cycle done pulse. Port P has priority, and a starvation limit guarantees forward progress for port D.

## Interface
- `DATA_W`, 64: data width of both ports and the memory.
- `ADDR_W`, 10: memory byte-address width; upper port address bits are ignored.
- `MEM_LAT`, 2: cycles from memory enable to valid `m_rdata`; legal range is ≥1.
- `STARVE_MAX`, 4: consecutive P grants allowed while D is waiting; legal range is ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `p_req`  in  1  pipeline access request; held until `p_done`.
- `p_we`  in  1  pipeline write (1) or read (0).
- `p_addr`  in  64  pipeline byte address.
- `p_wdata`  in  DATA_W  pipeline store data.
- `p_rdata`  out  DATA_W  pipeline result; valid while `p_done`.
- `p_done`  out  1  one-cycle completion pulse for P.
- `p_stall`  out  1  pipeline hold; combinational `p_req & ~p_done`.
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_rdata`, `d_done`: port D equivalents, same widths and rules.
- `m_en`  out  1  memory access strobe.
- `m_we`  out  1  memory write enable; qualified by `m_en`.
- `m_addr`  out  ADDR_W  memory address; low bits of the granted address.
- `m_wdata`  out  DATA_W  memory write data.
- `m_rdata`  in  DATA_W  memory read data; valid `MEM_LAT` cycles after `m_en`.
- `busy`  out  1  high whenever the state is not IDLE.
- `owner`  out  1  granted port (0 = P, 1 = D); holds its last value while in IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- IDLE → ISSUE when any request is high.
  - The winner's `we`, `addr` and `wdata` are latched at that edge; later changes to port inputs are ignored.
- ISSUE lasts one cycle with `m_en`=1 and the latched `m_we`, `m_addr` and `m_wdata`.
  - The `m_*` outputs are registered: `m_en` and `m_we` are 0 outside ISSUE.
  - `m_addr` and `m_wdata` hold their last values outside ISSUE.
- WAIT lasts `MEM_LAT` cycles, counted down from `MEM_LAT`-1 to 0.
  - On the last WAIT edge, `m_rdata` is captured for a read.
  - For a write, the latched `wdata` is captured instead, so the result equals the stored data.
- RESP lasts one cycle: the owner's `done`=1 and its `rdata` shows the captured value. Then RESP → IDLE.
  - `rdata` holds until the next completion on that port.
- Arbitration:
  - Only P requesting → grant P. Only D requesting → grant D.
  - Both requesting → grant P, unless `starve_cnt` == `STARVE_MAX`, in which case grant D.
- `starve_cnt`:
  - Increments on a P grant while `d_req`=1.
  - Clears on a D grant, or in any IDLE cycle where `d_req`=0.
  - Saturates at `STARVE_MAX`.
- A request that drops before its grant is simply not served. A request dropped after its grant still completes; its done pulse is issued and ignored.
- Reset mid-operation:
  - State returns to IDLE immediately; `m_en` and `m_we` go to 0 with no completion pulse.
  - An in-flight write may or may not have reached memory; the requester must reissue it.
- Reset values:
  - `p_done`, `d_done`, `m_en`, `m_we`, `busy` and `owner` are 0.
  - `p_rdata`, `d_rdata`, `m_addr` and `m_wdata` are 0.
  - `starve_cnt` and the latency counter are 0; state is IDLE.
  - `p_stall` follows `p_req` during reset.

## Timing
- Request first seen high in IDLE at cycle 0 gives ISSUE at cycle 1 and WAIT at cycles 2 to `MEM_LAT`+1.
- `done` rises at cycle `MEM_LAT`+2; the next grant can occur at cycle `MEM_LAT`+3.
- Latency is `MEM_LAT`+2 cycles from request to done; throughput is one access per `MEM_LAT`+3 cycles.
- `p_stall` drops in the same cycle `p_done` rises, so the pipeline advances on that edge.

## Structure
- Shared definitions go in the common Verilog include:
  - FSM state encodings `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`.
  - Owner codes `OWN_P` and `OWN_D`.
- One sub-module, `arb_lat_counter`: a loadable down-counter with a terminal-count flag, sized `$clog2(MEM_LAT)`+1.
- Arbitration and starvation logic stay in the top level.

## Test plan
All scenarios use `MEM_LAT`=2 and `STARVE_MAX`=4.
- **Read from P.** Stimulus: `p_req` with read, `p_addr`=0x10, memory returns 0xDEAD at cycle 3. Required: `m_en` only at cycle 1 with `m_addr`=0x10; `p_done` at cycle 4 with `p_rdata`=0xDEAD; `p_stall` high at cycles 0–3.
- **Write from D.** Stimulus: `d_req` with write, `d_addr`=0x20, `d_wdata`=0x1234. Required: `m_en`=1, `m_we`=1 and `m_wdata`=0x1234 at cycle 1; `d_done` at cycle 4 with `d_rdata`=0x1234; `owner`=1.
- **Simultaneous requests.** Stimulus: `p_req` and `d_req` asserted together, P re-requesting immediately after each done. Required: P is granted four times, then D on the fifth grant, then `starve_cnt` returns to 0.
- **Reset during WAIT.** Stimulus: assert `rst` in WAIT. Required: `busy`, `m_en` and `done` all 0 immediately; the next request after reset completes with normal latency.
- **Back-to-back P reads.** Stimulus: two consecutive P reads. Required: `p_done` pulses at cycles 4 and 9, each exactly one cycle wide.
- **Input changes after grant.** Stimulus: `p_addr` changes after the grant edge. Required: `m_addr` keeps the latched value.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and codes for the data-memory arbiter.
package dmem_arbiter_pkg;

   // Access sequencer states
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;

   // Owner codes reported on the owner output
   localparam logic OWN_P = 1'b0;
   localparam logic OWN_D = 1'b1;

   // D wins when it is the only requester, or when P has starved it long enough
   function automatic logic grant_to_d(input logic p_req, input logic d_req, input logic starved);
      return d_req & (~p_req | starved);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, memory and status signals around the arbiter.
// slave is the arbiter's view; master is the view of the requesters and memory.
interface dmem_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 10
);
   logic              p_req;
   logic              p_we;
   logic [63:0]       p_addr;
   logic [DATA_W-1:0] p_wdata;
   logic [DATA_W-1:0] p_rdata;
   logic              p_done;
   logic              p_stall;

   logic              d_req;
   logic              d_we;
   logic [63:0]       d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;

   logic              m_en;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;

   logic              busy;
   logic              owner;

   modport slave (
      input  p_req, p_we, p_addr, p_wdata,
      output p_rdata, p_done, p_stall,
      input  d_req, d_we, d_addr, d_wdata,
      output d_rdata, d_done,
      output m_en, m_we, m_addr, m_wdata,
      input  m_rdata,
      output busy, owner
   );

   modport master (
      output p_req, p_we, p_addr, p_wdata,
      input  p_rdata, p_done, p_stall,
      output d_req, d_we, d_addr, d_wdata,
      input  d_rdata, d_done,
      input  m_en, m_we, m_addr, m_wdata,
      output m_rdata,
      input  busy, owner
   );
endinterface

// File: rtl/dmem_arbiter_lat_counter.sv
// Loadable down-counter timing the memory latency; o_tc flags a zero count.
module arb_lat_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_tc
);
   logic [WIDTH-1:0] r_count;

   // Load takes precedence; otherwise count down and stop at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && !o_tc) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_tc = (r_count == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port sequencer/arbiter for the single-port data memory.
// P has priority; D is guaranteed a grant after STARVE_MAX consecutive P grants.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 10,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(MEM_LAT) + 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);

   arb_state_t        r_state;
   logic              r_we;
   logic [STV_W-1:0]  r_starve;

   logic              w_any_req;
   logic              w_starved;
   logic              w_grant_d;
   logic              w_cnt_load;
   logic              w_cnt_en;
   logic              w_tc;
   logic [DATA_W-1:0] w_result;
   logic              w_unused_addr;

   assign w_any_req  = bus.p_req | bus.d_req;
   assign w_starved  = (r_starve == STV_W'(STARVE_MAX));
   assign w_grant_d  = grant_to_d(bus.p_req, bus.d_req, w_starved);
   assign w_cnt_load = (r_state == ARB_ISSUE);
   assign w_cnt_en   = (r_state == ARB_WAIT);
   // A write reports the data it stored, held in m_wdata since the grant
   assign w_result   = r_we ? bus.m_wdata : bus.m_rdata;

   // Only the low address bits reach the memory
   assign w_unused_addr = ^{bus.p_addr[63:ADDR_W], bus.d_addr[63:ADDR_W]};

   assign bus.busy    = (r_state != ARB_IDLE);
   assign bus.p_stall = bus.p_req & ~bus.p_done;

   arb_lat_counter #(
      .WIDTH (CNT_W)
   ) u_lat_counter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_cnt_load),
      .i_load_val (CNT_W'(MEM_LAT - 1)),
      .i_en       (w_cnt_en),
      .o_tc       (w_tc)
   );

   // Sequencer: grant and latch in IDLE, strobe memory in ISSUE, wait out the latency, respond
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ARB_IDLE;
         r_we        <= 1'b0;
         r_starve    <= '0;
         bus.owner   <= OWN_P;
         bus.p_done  <= 1'b0;
         bus.d_done  <= 1'b0;
         bus.p_rdata <= '0;
         bus.d_rdata <= '0;
         bus.m_en    <= 1'b0;
         bus.m_we    <= 1'b0;
         bus.m_addr  <= '0;
         bus.m_wdata <= '0;
      end else begin
         bus.p_done <= 1'b0;
         bus.d_done <= 1'b0;
         bus.m_en   <= 1'b0;
         bus.m_we   <= 1'b0;
         case (r_state)
            ARB_IDLE: begin
               if (!bus.d_req) begin
                  r_starve <= '0;
               end
               if (w_any_req) begin
                  r_state  <= ARB_ISSUE;
                  bus.m_en <= 1'b1;
                  if (w_grant_d) begin
                     bus.owner   <= OWN_D;
                     r_we        <= bus.d_we;
                     bus.m_we    <= bus.d_we;
                     bus.m_addr  <= bus.d_addr[ADDR_W-1:0];
                     bus.m_wdata <= bus.d_wdata;
                     r_starve    <= '0;
                  end else begin
                     bus.owner   <= OWN_P;
                     r_we        <= bus.p_we;
                     bus.m_we    <= bus.p_we;
                     bus.m_addr  <= bus.p_addr[ADDR_W-1:0];
                     bus.m_wdata <= bus.p_wdata;
                     if (bus.d_req && !w_starved) begin
                        r_starve <= r_starve + STV_W'(1);
                     end
                  end
               end
            end
            ARB_ISSUE: begin
               r_state <= ARB_WAIT;
            end
            ARB_WAIT: begin
               if (w_tc) begin
                  r_state <= ARB_RESP;
                  if (bus.owner == OWN_D) begin
                     bus.d_done  <= 1'b1;
                     bus.d_rdata <= w_result;
                  end else begin
                     bus.p_done  <= 1'b1;
                     bus.p_rdata <= w_result;
                  end
               end
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule
